// File: rtl/mdu_defs_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// default latency constants.
package mdu_defs;

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMthi  = 4'd5,
    OpMtlo  = 4'd6,
    OpMfhi  = 4'd7,
    OpMflo  = 4'd8
  } mdu_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } mdu_state_e;

  localparam int unsigned DefMultCycles = 5;
  localparam int unsigned DefDivCycles  = 10;
  localparam int unsigned CntW          = 8;

endpackage

// File: rtl/mdu_unit.sv
// Execute-stage multiply/divide unit owning HI/LO. Results are computed at start,
// held in shadow registers and committed after a fixed busy period.
module mdu_unit
  import mdu_defs::*;
#(
  parameter int unsigned MULT_CYCLES = DefMultCycles,
  parameter int unsigned DIV_CYCLES  = DefDivCycles
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_rd
);

  mdu_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic             skip_q, skip_d;

  mdu_op_e          op_c;
  logic             is_mult, is_div, div_zero;
  logic signed [63:0] prod_s;
  logic [63:0]      prod_u;
  logic signed [31:0] a_s, b_s;
  logic [31:0]      res_hi, res_lo;

  assign op_c     = mdu_op_e'(op);
  assign is_mult  = (op_c == OpMult) || (op_c == OpMultu);
  assign is_div   = (op_c == OpDiv) || (op_c == OpDivu);
  assign div_zero = is_div && (B == 32'd0);
  assign a_s      = A;
  assign b_s      = B;

  always_comb begin
    prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u = {32'd0, A} * {32'd0, B};
    res_hi = 32'd0;
    res_lo = 32'd0;
    unique case (op_c)
      OpMult:  {res_hi, res_lo} = prod_s;
      OpMultu: {res_hi, res_lo} = prod_u;
      OpDiv: begin
        // Most-negative / -1 overflows; the quotient wraps to the dividend.
        if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else if (B != 32'd0) begin
          res_lo = a_s / b_s;
          res_hi = a_s % b_s;
        end
      end
      OpDivu: begin
        if (B != 32'd0) begin
          res_lo = A / B;
          res_hi = A % B;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    skip_d  = skip_q;
    unique case (state_q)
      StIdle: begin
        if (!req) begin
          if (start && (is_mult || is_div)) begin
            state_d = StRun;
            cnt_d   = is_mult ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
            sh_hi_d = res_hi;
            sh_lo_d = res_lo;
            skip_d  = div_zero;
          end else if (op_c == OpMthi) begin
            hi_d = A;
          end else if (op_c == OpMtlo) begin
            lo_d = A;
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          // Divide by zero keeps the architectural HI/LO untouched.
          if (!skip_q) begin
            hi_d = sh_hi_q;
            lo_d = sh_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      skip_q  <= skip_d;
    end
  end

  assign busy = (state_q == StRun);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    mdu_rd = 32'd0;
    if (op_c == OpMfhi)      mdu_rd = hi_q;
    else if (op_c == OpMflo) mdu_rd = lo_q;
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed corner cases plus random
// multiply/divide traffic checked against an arithmetic reference model.
module tb_mdu_unit;
  import mdu_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A, B;
  logic        req;
  logic        busy;
  logic [31:0] hi, lo, mdu_rd;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  mdu_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .req    (req),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .mdu_rd (mdu_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  // Reference arithmetic from sign/magnitude rules, independent of RTL structure.
  task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          ps;
    longint unsigned pu;
    logic [31:0]     ua, ub, q, r;
    case (o)
      4'd1: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        hi_m = ps[63:32];
        lo_m = ps[31:0];
      end
      4'd2: begin
        pu = longint'({32'd0, a}) * longint'({32'd0, b});
        hi_m = pu[63:32];
        lo_m = pu[31:0];
      end
      4'd3: if (b != 0) begin
        ua = a[31] ? -a : a;
        ub = b[31] ? -b : b;
        q  = ua / ub;
        r  = ua % ub;
        lo_m = (a[31] ^ b[31]) ? -q : q;
        hi_m = a[31] ? -r : r;
      end
      4'd4: if (b != 0) begin
        lo_m = a / b;
        hi_m = a % b;
      end
      default: ;
    endcase
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    int exp_n;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = OpNone; A = 32'd0; B = 32'd0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    exp_n = (o == OpMult || o == OpMultu) ? 5 : 10;
    check({tag, "_busy_len"}, 32'(n), 32'(exp_n));
    model(o, a, b);
    check({tag, "_hi"}, hi, hi_m);
    check({tag, "_lo"}, lo, lo_m);
  endtask

  task automatic move_to(input string tag, input logic [3:0] o, input logic [31:0] a);
    @(negedge clk);
    op = o; A = a;
    @(negedge clk);
    op = OpNone; A = 32'd0;
    if (o == OpMthi) hi_m = a;
    else lo_m = a;
    check({tag, "_hi"}, hi, hi_m);
    check({tag, "_lo"}, lo, lo_m);
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = OpNone; A = 32'd0; B = 32'd0; req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    move_to("mthi", OpMthi, 32'h0000_1234);
    check("mthi_busy", {31'd0, busy}, 32'd0);

    run_op("mult", OpMult, 32'hFFFF_FFFE, 32'h0000_0003);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFFA);

    run_op("multu", OpMultu, 32'hFFFF_FFFE, 32'h0000_0003);
    check("multu_hi_const", hi, 32'h0000_0002);
    op = OpMfhi; #1;
    check("mfhi_rd", mdu_rd, 32'h0000_0002);
    op = OpMflo; #1;
    check("mflo_rd", mdu_rd, 32'hFFFF_FFFA);
    op = OpNone; #1;
    check("none_rd", mdu_rd, 32'd0);

    run_op("div", OpDiv, 32'hFFFF_FFF9, 32'h0000_0002);
    check("div_lo_const", lo, 32'hFFFF_FFFD);
    check("div_hi_const", hi, 32'hFFFF_FFFF);
    run_op("divu", OpDivu, 32'hFFFF_FFF9, 32'h0000_0002);
    check("divu_lo_const", lo, 32'h7FFF_FFFC);
    check("divu_hi_const", hi, 32'h0000_0001);

    run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo_const", lo, 32'h8000_0000);

    move_to("set_hi", OpMthi, 32'h11);
    move_to("set_lo", OpMtlo, 32'h22);
    run_op("div0", OpDiv, 32'h0000_0064, 32'd0);
    check("div0_hi_const", hi, 32'h11);
    check("div0_lo_const", lo, 32'h22);

    // start together with req must not launch anything.
    @(negedge clk);
    start = 1'b1; op = OpMult; A = 32'h7; B = 32'h9; req = 1'b1;
    @(negedge clk);
    start = 1'b0; op = OpNone; req = 1'b0;
    check("req_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("req_busy2", {31'd0, busy}, 32'd0);
    check("req_hi", hi, hi_m);
    check("req_lo", lo, lo_m);

    // MTHI under req is suppressed too.
    @(negedge clk);
    op = OpMthi; A = 32'hDEAD; req = 1'b1;
    @(negedge clk);
    op = OpNone; req = 1'b0;
    check("req_mthi", hi, hi_m);

    for (int i = 0; i < 12; i++) begin
      ro = 4'($urandom_range(1, 4));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (i % 3 == 0) rb = 32'($urandom_range(1, 20));
      run_op($sformatf("rnd%0d", i), ro, ra, rb);
    end

    // Reset during the third busy cycle aborts at once.
    @(negedge clk);
    start = 1'b1; op = OpDiv; A = 32'h1234_5678; B = 32'h3;
    @(negedge clk);
    start = 1'b0; op = OpNone;
    check("abort_busy1", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    hi_m = 32'd0; lo_m = 32'd0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_commit_lo", lo, 32'd0);
    move_to("mtlo5", OpMtlo, 32'd5);
    check("mtlo5_const", lo, 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the Execute stage; owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the E-stage decoder.
- Drives busy back to the hazard controller, which stalls F/D while start or busy is high.
- Multi-cycle latency is modelled with a countdown counter; results commit to HI/LO at the end.

Parameters:
- MULT_CYCLES, 5, busy-cycle count for MULT/MULTU.
- DIV_CYCLES, 10, busy-cycle count for DIV/DIVU.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  E-stage instruction is MULT/MULTU/DIV/DIVU; qualified by op.
- op  in  4  operation code (see Decomposition).
- A  in  32  forwarded rs operand.
- B  in  32  forwarded rt operand.
- req  in  1  exception/interrupt flush this cycle; suppresses new start and MTHI/MTLO.
- busy  out  1  operation in progress.
- hi  out  32  HI register.
- lo  out  32  LO register.
- mdu_rd  out  32  read data: hi when op=MFHI, lo when op=MFLO, else 0; combinational.

Behaviour:
- Reset, asynchronous and taking effect immediately:
  - state=IDLE, busy=0, hi=0, lo=0, counter=0.
  - Pending shadow result discarded.
- States:
  - IDLE: waiting for a command.
  - RUN: counting down.
- IDLE transitions, evaluated at each rising edge:
  - start=1, req=0, op in {MULT,MULTU,DIV,DIVU}: latch result into shadow_hi/shadow_lo, load counter with MULT_CYCLES or DIV_CYCLES, go to RUN.
  - start=1 with any other op: ignored.
  - op=MTHI, req=0: hi<=A.
  - op=MTLO, req=0: lo<=A.
  - MTHI/MTLO ignore start.
- Busy timing:
  - busy is registered; it is 1 from the edge after the start cycle for exactly N cycles.
  - At the edge ending the Nth busy cycle: counter reaches 0, hi/lo<=shadow, busy<=0, state=IDLE.
  - New hi/lo are visible in the first cycle busy reads 0.
- RUN:
  - start, MTHI and MTLO are ignored; the hazard controller guarantees none arrive.
  - req does not abort an in-flight operation (the instruction already left E).
  - MFHI/MFLO during RUN return the old hi/lo; the stall prevents consuming them.
- Arithmetic:
  - MULT: {hi,lo} = signed(A)*signed(B), full 64-bit product.
  - MULTU: {hi,lo} = unsigned product.
  - DIV: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (B=0):
  - Full DIV_CYCLES busy period still runs.
  - hi/lo remain unchanged at commit.
- Simultaneous events:
  - start and req in the same cycle: no operation starts, busy stays 0.
  - Reset during RUN: aborts immediately, hi=lo=0.

Decomposition:
- Shared package mdu_defs:
  - op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
  - state encodings IDLE/RUN.
  - default cycle constants.
- No sub-module needed; arithmetic is inline in a combinational block feeding the shadow registers.

Test Plan:
- Reset, then op=MTHI, A=0x00001234 for one cycle -> hi=0x00001234 next cycle, busy=0, lo=0.
- MULT, A=0xFFFFFFFE, B=0x00000003, start one cycle:
  - busy=1 for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU, same operands:
  - busy 5 cycles.
  - Then hi=0x00000002, lo=0xFFFFFFFA; op=MFHI -> mdu_rd=0x00000002.
- DIV, A=0xFFFFFFF9 (-7), B=0x00000002:
  - busy 10 cycles.
  - Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU, same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- DIV with B=0 after hi=0x11, lo=0x22:
  - busy 10 cycles.
  - hi=0x11, lo=0x22 unchanged.
- Start and reset corner cases:
  - start=1, op=MULT, req=1 -> busy stays 0, hi/lo unchanged.
  - DIV started, reset pulsed in busy cycle 3 -> busy=0, hi=lo=0 immediately.
  - Subsequent MTLO A=5 -> lo=5.
